urng_stream_checker: RTL

- Receive-side checker for the three-component Tausworthe uniform random stream used for LDPC channel-noise generation.
- Seeded with the same three 32-bit seeds as the source. Runs its own copy of the recurrence and advances once per accepted word.
- Compares each accepted word, acquires lock, then counts errors and declares loss. Used in simulation benches and on-chip to qualify the noise source before decoder BER runs.

---
 rtl/urng_stream_checker_if.sv | 21 ++
 rtl/urng_stream_checker.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/urng_stream_checker_if.sv
// ---------------------------------------------------------------------------
// urng_stream_checker_if
//   Receive-word bus for the Tausworthe stream checker. No backpressure:
//   every cycle with in_valid high carries one word that the consumer
//   must accept.
//
//   Signals:
//     in_valid  in_data holds a received word this cycle
//     in_data   32-bit received random word
//
//   Modports:
//     master  drives the word stream (source / testbench)
//     slave   consumes the word stream (checker)
// ---------------------------------------------------------------------------
interface urng_stream_checker_if;
  logic        in_valid;
  logic [31:0] in_data;

  modport master (output in_valid, output in_data);
  modport slave  (input  in_valid, input  in_data);
endinterface

// File: rtl/urng_stream_checker.sv
// ---------------------------------------------------------------------------
// urng_stream_checker
//   Receive-side checker for a three-component Tausworthe uniform random
//   stream. It runs a local copy of the recurrence, seeded like the source,
//   and advances it once per compared word. After LOCK_N consecutive
//   matches it is LOCKED; in LOCKED, mismatches are counted and LOSS_N
//   consecutive mismatches drive it into a sticky FAIL.
//
//   Ports:
//     clk, rst        clock; asynchronous active-low reset
//     seed0..seed2    component seeds, loaded on start
//     start           one-cycle pulse: load seeds, clear counters, HUNT
//     in_bus          slave side of the received word stream
//     state           00 IDLE, 01 HUNT, 10 LOCKED, 11 FAIL
//     locked, fail    state decodes
//     err_pulse       one-cycle pulse per mismatch counted in LOCKED
//     err_cnt         LOCKED mismatches, saturating
//     word_cnt        words compared in HUNT/LOCKED, saturating
//     bit_err_cnt     (URNG_CHK_BITERR_EN only) sum of bit errors in LOCKED
//
//   Optional feature macro: URNG_CHK_BITERR_EN adds bit_err_cnt.
//   All output updates appear one cycle after the word is presented.
// ---------------------------------------------------------------------------
module urng_stream_checker #(
  parameter int unsigned LOCK_N = 8,
  parameter int unsigned LOSS_N = 4,
  parameter int unsigned ERR_W  = 16,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          seed0,
  input  logic [31:0]          seed1,
  input  logic [31:0]          seed2,
  input  logic                 start,
  urng_stream_checker_if.slave in_bus,
  output logic [1:0]           state,
  output logic                 locked,
  output logic                 fail,
  output logic                 err_pulse,
  output logic [ERR_W-1:0]     err_cnt,
  output logic [CNT_W-1:0]     word_cnt
`ifdef URNG_CHK_BITERR_EN
  ,
  output logic [31:0]          bit_err_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_HUNT   = 2'b01,
    ST_LOCKED = 2'b10,
    ST_FAIL   = 2'b11
  } state_t;

  localparam logic [7:0] LOCK_N8 = 8'(LOCK_N);
  localparam logic [7:0] LOSS_N8 = 8'(LOSS_N);

  state_t           state_reg, state_next;
  logic [31:0]      s0_reg, s0_next;
  logic [31:0]      s1_reg, s1_next;
  logic [31:0]      s2_reg, s2_next;
  logic [7:0]       match_run_reg, match_run_next;
  logic [7:0]       miss_run_reg, miss_run_next;
  logic [ERR_W-1:0] err_cnt_reg, err_cnt_next;
  logic [CNT_W-1:0] word_cnt_reg, word_cnt_next;
  logic             err_pulse_reg, err_pulse_next;

  logic [31:0] exp_word;
  logic        compare;
  logic        match;

  // One recurrence step per component; 32-bit logical shifts, truncating.
  function automatic logic [31:0] step0(input logic [31:0] s);
    return ((s & 32'hFFFF_FFFE) << 12) ^ (((s << 13) ^ s) >> 19);
  endfunction

  function automatic logic [31:0] step1(input logic [31:0] s);
    return ((s & 32'hFFFF_FFF8) << 4) ^ (((s << 2) ^ s) >> 25);
  endfunction

  function automatic logic [31:0] step2(input logic [31:0] s);
    return ((s & 32'hFFFF_FFF0) << 17) ^ (((s << 3) ^ s) >> 11);
  endfunction

  assign exp_word = s0_reg ^ s1_reg ^ s2_reg;
  assign compare  = in_bus.in_valid &&
                    (state_reg == ST_HUNT || state_reg == ST_LOCKED);
  assign match    = (in_bus.in_data == exp_word);

`ifdef URNG_CHK_BITERR_EN
  logic [31:0] bit_err_reg, bit_err_next;
  logic [5:0]  pop;
  logic [32:0] bit_sum;

  assign pop     = 6'($countones(in_bus.in_data ^ exp_word));
  assign bit_sum = {1'b0, bit_err_reg} + {27'd0, pop};

  always_comb begin
    bit_err_next = bit_err_reg;
    if (start) begin
      bit_err_next = '0;
    end else if (compare && state_reg == ST_LOCKED) begin
      bit_err_next = bit_sum[32] ? 32'hFFFF_FFFF : bit_sum[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bit_err_reg <= '0;
    else      bit_err_reg <= bit_err_next;
  end

  assign bit_err_cnt = bit_err_reg;
`endif

  always_comb begin
    state_next     = state_reg;
    s0_next        = s0_reg;
    s1_next        = s1_reg;
    s2_next        = s2_reg;
    match_run_next = match_run_reg;
    miss_run_next  = miss_run_reg;
    err_cnt_next   = err_cnt_reg;
    word_cnt_next  = word_cnt_reg;
    err_pulse_next = 1'b0;

    if (start) begin
      // start wins over any word presented in the same cycle
      state_next     = ST_HUNT;
      s0_next        = seed0;
      s1_next        = seed1;
      s2_next        = seed2;
      match_run_next = '0;
      miss_run_next  = '0;
      err_cnt_next   = '0;
      word_cnt_next  = '0;
    end else if (compare) begin
      s0_next = step0(s0_reg);
      s1_next = step1(s1_reg);
      s2_next = step2(s2_reg);
      if (word_cnt_reg != '1) word_cnt_next = word_cnt_reg + 1'b1;

      if (state_reg == ST_HUNT) begin
        if (match) begin
          match_run_next = match_run_reg + 8'd1;
          if (match_run_reg + 8'd1 == LOCK_N8) begin
            state_next     = ST_LOCKED;
            match_run_next = '0;
            miss_run_next  = '0;
          end
        end else begin
          match_run_next = '0;
        end
      end else begin
        if (match) begin
          miss_run_next = '0;
        end else begin
          err_pulse_next = 1'b1;
          if (err_cnt_reg != '1) err_cnt_next = err_cnt_reg + 1'b1;
          miss_run_next = miss_run_reg + 8'd1;
          if (miss_run_reg + 8'd1 == LOSS_N8) state_next = ST_FAIL;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      s0_reg        <= '0;
      s1_reg        <= '0;
      s2_reg        <= '0;
      match_run_reg <= '0;
      miss_run_reg  <= '0;
      err_cnt_reg   <= '0;
      word_cnt_reg  <= '0;
      err_pulse_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      s0_reg        <= s0_next;
      s1_reg        <= s1_next;
      s2_reg        <= s2_next;
      match_run_reg <= match_run_next;
      miss_run_reg  <= miss_run_next;
      err_cnt_reg   <= err_cnt_next;
      word_cnt_reg  <= word_cnt_next;
      err_pulse_reg <= err_pulse_next;
    end
  end

  assign state     = state_reg;
  assign locked    = (state_reg == ST_LOCKED);
  assign fail      = (state_reg == ST_FAIL);
  assign err_pulse = err_pulse_reg;
  assign err_cnt   = err_cnt_reg;
  assign word_cnt  = word_cnt_reg;

endmodule
